// File: rtl/sim_controller_pkg.sv
// rtl/sim_controller_pkg.sv - shared widths, FSM encoding and click entry type
//
// Purpose: board/speed/seed widths used across the sequencing stage, the
// controller state encoding and the packed {y, x} click FIFO entry.
package sim_controller_pkg;

    localparam int LOG_BOARD_SIZE = 6;
    localparam int LOG_MAX_SPEED  = 4;
    localparam int LOG_NUM_SEED   = 2;

    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t LOAD      = 3'd0;
    localparam ctrl_state_t IDLE      = 3'd1;
    localparam ctrl_state_t EDIT      = 3'd2;
    localparam ctrl_state_t STEP_REQ  = 3'd3;
    localparam ctrl_state_t STEP_WAIT = 3'd4;

    typedef struct packed {
        logic [LOG_BOARD_SIZE-1:0] y;
        logic [LOG_BOARD_SIZE-1:0] x;
    } click_entry_t;

    // Frames between generation steps: 2**LOG_MAX_SPEED - speed.
    function automatic logic [LOG_MAX_SPEED:0] step_period(
        input logic [LOG_MAX_SPEED-1:0] speed
    );
        return {1'b1, {LOG_MAX_SPEED{1'b0}}} - {1'b0, speed};
    endfunction

endpackage

// File: rtl/click_fifo.sv
// rtl/click_fifo.sv - small synchronous FIFO with flush for buffered clicks
//
// Purpose: holds click entries while the engine is busy.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   push, din      : write request and data (dropped when full, unless popping)
//   pop, dout      : read request and head-of-queue data (combinational)
//   flush          : discard all contents
//   full, empty    : occupancy flags
module click_fifo #(
    parameter int WIDTH     = 12,
    parameter int LOG_DEPTH = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [1 << LOG_DEPTH];
    logic [LOG_DEPTH:0] wr_ptr;
    logic [LOG_DEPTH:0] rd_ptr;
    logic do_push;
    logic do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                     (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is kept then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[LOG_DEPTH-1:0]];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push && !flush) mem[wr_ptr[LOG_DEPTH-1:0]] <= din;
    end

endmodule

// File: rtl/sim_controller.sv
// rtl/sim_controller.sv - sequences seed loads, cell edits and generation steps
//
// Purpose: turns clicks, speed, seed selection and frame ticks into mutually
// exclusive requests to the board/life-engine stage.
// Ports:
//   clk_in, rst_in                       : clock, asynchronous active-high reset
//   click_in, cursor_x_in, cursor_y_in   : click pulse and cursor cell
//   speed_in, seed_idx_in, vsync_in      : speed (0 = paused), seed select, vsync
//   seed_load_out, seed_idx_out, seed_done_in          : seed load request
//   edit_valid_out, edit_x_out, edit_y_out, edit_ready_in : toggle request
//   step_valid_out, step_ready_in, step_done_in        : generation step request
//   paused_out                           : registered speed_in == 0
module sim_controller
    import sim_controller_pkg::*;
#(
    parameter int LOG_CLICK_DEPTH = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      click_in,
    input  logic [LOG_MAX_SPEED-1:0]  speed_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    input  logic [LOG_NUM_SEED-1:0]   seed_idx_in,
    input  logic                      vsync_in,
    output logic                      seed_load_out,
    output logic [LOG_NUM_SEED-1:0]   seed_idx_out,
    input  logic                      seed_done_in,
    output logic                      edit_valid_out,
    output logic [LOG_BOARD_SIZE-1:0] edit_x_out,
    output logic [LOG_BOARD_SIZE-1:0] edit_y_out,
    input  logic                      edit_ready_in,
    output logic                      step_valid_out,
    input  logic                      step_ready_in,
    input  logic                      step_done_in,
    output logic                      paused_out
);

    localparam int ENTRY_W = $bits(click_entry_t);

    ctrl_state_t              state;
    logic                     vsync_q;
    logic                     frame_tick;
    logic [LOG_MAX_SPEED-1:0] frame_cnt;
    logic [LOG_MAX_SPEED:0]   cnt_inc;
    logic                     pending;
    logic                     seed_change;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_flush;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [ENTRY_W-1:0]       fifo_dout;
    click_entry_t             fifo_head;
    click_entry_t             fifo_din;

    assign seed_change = (seed_idx_in != seed_idx_out);
    assign fifo_din    = '{y: cursor_y_in, x: cursor_x_in};
    assign fifo_head   = click_entry_t'(fifo_dout);
    assign fifo_push   = click_in && (state != LOAD) && (!fifo_full || fifo_pop);
    // A seed change outranks queued clicks: they belong to the old board.
    assign fifo_pop    = (state == IDLE) && !seed_change && !fifo_empty;
    assign fifo_flush  = (state == IDLE) && seed_change;
    assign cnt_inc     = {1'b0, frame_cnt} + {{LOG_MAX_SPEED{1'b0}}, 1'b1};

    click_fifo #(
        .WIDTH     (ENTRY_W),
        .LOG_DEPTH (LOG_CLICK_DEPTH)
    ) u_click_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .flush  (fifo_flush),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Registered rising-edge detect: the tick lands one cycle after the edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vsync_q    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync_in;
            frame_tick <= vsync_in && !vsync_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= LOAD;
            seed_load_out  <= 1'b1;
            seed_idx_out   <= '0;
            edit_valid_out <= 1'b0;
            edit_x_out     <= '0;
            edit_y_out     <= '0;
            step_valid_out <= 1'b0;
            paused_out     <= 1'b1;
            frame_cnt      <= '0;
            pending        <= 1'b0;
        end else begin
            paused_out <= (speed_in == '0);

            if ((state == STEP_REQ) && step_ready_in) pending <= 1'b0;

            // A step falling due in the handshake cycle is a new one, so the set wins.
            if (frame_tick && (speed_in != '0)) begin
                if (cnt_inc >= step_period(speed_in)) begin
                    pending   <= 1'b1;
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= cnt_inc[LOG_MAX_SPEED-1:0];
                end
            end

            case (state)
                LOAD: begin
                    if (seed_done_in) begin
                        state         <= IDLE;
                        seed_load_out <= 1'b0;
                        frame_cnt     <= '0;
                        pending       <= 1'b0;
                    end
                end
                IDLE: begin
                    if (seed_change) begin
                        seed_idx_out  <= seed_idx_in;
                        seed_load_out <= 1'b1;
                        state         <= LOAD;
                    end else if (!fifo_empty) begin
                        edit_x_out     <= fifo_head.x;
                        edit_y_out     <= fifo_head.y;
                        edit_valid_out <= 1'b1;
                        state          <= EDIT;
                    end else if (pending) begin
                        step_valid_out <= 1'b1;
                        state          <= STEP_REQ;
                    end
                end
                EDIT: begin
                    if (edit_ready_in) begin
                        edit_valid_out <= 1'b0;
                        state          <= IDLE;
                    end
                end
                STEP_REQ: begin
                    if (step_ready_in) begin
                        step_valid_out <= 1'b0;
                        state          <= STEP_WAIT;
                    end
                end
                STEP_WAIT: begin
                    if (step_done_in) state <= IDLE;
                end
                default: begin
                    state          <= LOAD;
                    seed_load_out  <= 1'b1;
                    edit_valid_out <= 1'b0;
                    step_valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_controller.sv
// tb/tb_sim_controller.sv - self-checking bench for sim_controller
module tb_sim_controller;
    import sim_controller_pkg::*;

    logic                      clk_in = 1'b0;
    logic                      rst_in = 1'b1;
    logic                      click_in = 1'b0;
    logic [LOG_MAX_SPEED-1:0]  speed_in = '0;
    logic [LOG_BOARD_SIZE-1:0] cursor_x_in = '0;
    logic [LOG_BOARD_SIZE-1:0] cursor_y_in = '0;
    logic [LOG_NUM_SEED-1:0]   seed_idx_in = '0;
    logic                      vsync_in = 1'b0;
    logic                      seed_load_out;
    logic [LOG_NUM_SEED-1:0]   seed_idx_out;
    logic                      seed_done_in = 1'b0;
    logic                      edit_valid_out;
    logic [LOG_BOARD_SIZE-1:0] edit_x_out;
    logic [LOG_BOARD_SIZE-1:0] edit_y_out;
    logic                      edit_ready_in = 1'b1;
    logic                      step_valid_out;
    logic                      step_ready_in = 1'b1;
    wire                       step_done_in;
    logic                      paused_out;

    logic auto_done   = 1'b1;
    logic auto_pulse  = 1'b0;
    logic manual_done = 1'b0;
    logic done_pend   = 1'b0;
    assign step_done_in = auto_pulse | manual_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int step_hs = 0;
    logic step_seen = 1'b0;
    int ex_q[$];
    int ey_q[$];
    int ec_q[$];

    sim_controller #(.LOG_CLICK_DEPTH(2)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .click_in       (click_in),
        .speed_in       (speed_in),
        .cursor_x_in    (cursor_x_in),
        .cursor_y_in    (cursor_y_in),
        .seed_idx_in    (seed_idx_in),
        .vsync_in       (vsync_in),
        .seed_load_out  (seed_load_out),
        .seed_idx_out   (seed_idx_out),
        .seed_done_in   (seed_done_in),
        .edit_valid_out (edit_valid_out),
        .edit_x_out     (edit_x_out),
        .edit_y_out     (edit_y_out),
        .edit_ready_in  (edit_ready_in),
        .step_valid_out (step_valid_out),
        .step_ready_in  (step_ready_in),
        .step_done_in   (step_done_in),
        .paused_out     (paused_out)
    );

    always #5 clk_in = ~clk_in;

    // Handshake monitor and step-done responder, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk_in);
            cyc++;
            auto_pulse = done_pend && auto_done;
            done_pend  = 1'b0;
            if (step_valid_out) step_seen = 1'b1;
            if (step_valid_out && step_ready_in) begin
                step_hs++;
                done_pend = 1'b1;
            end
            if (edit_valid_out && edit_ready_in) begin
                ex_q.push_back(int'(edit_x_out));
                ey_q.push_back(int'(edit_y_out));
                ec_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frame();
        vsync_in = 1'b1;
        repeat (2) @(negedge clk_in);
        vsync_in = 1'b0;
        repeat (12) @(negedge clk_in);
    endtask

    task automatic click(input int x, input int y);
        cursor_x_in = LOG_BOARD_SIZE'(x);
        cursor_y_in = LOG_BOARD_SIZE'(y);
        click_in = 1'b1;
        @(negedge clk_in);
        click_in = 1'b0;
    endtask

    task automatic pulse_seed_done();
        seed_done_in = 1'b1;
        @(negedge clk_in);
        seed_done_in = 1'b0;
    endtask

    task automatic pulse_step_done();
        manual_done = 1'b1;
        @(negedge clk_in);
        manual_done = 1'b0;
    endtask

    // Issue one step and leave the controller parked in STEP_WAIT.
    task automatic park_in_step_wait(input string name);
        int base;
        base = step_hs;
        auto_done = 1'b0;
        speed_in = 4'd15;
        repeat (2) @(negedge clk_in);
        frame();
        speed_in = 4'd0;
        for (int i = 0; i < 50 && step_hs == base; i++) @(negedge clk_in);
        check(name, step_hs - base, 1);
    endtask

    typedef struct {
        logic [LOG_MAX_SPEED-1:0] speed;
        int frames;
        int exp_steps;
        int exp_paused;
    } cad_vec_t;

    cad_vec_t cad_tbl[7];
    int exp_edit_x[4];
    int exp_edit_y[4];

    initial begin
        int base;
        int nedits;
        logic seen_valid;

        cad_tbl[0] = '{4'd14, 6, 3, 0};
        cad_tbl[1] = '{4'd15, 4, 4, 0};
        cad_tbl[2] = '{4'd13, 6, 2, 0};
        cad_tbl[3] = '{4'd0, 20, 0, 1};
        cad_tbl[4] = '{4'd12, 8, 2, 0};
        cad_tbl[5] = '{4'd14, 3, 1, 0};
        cad_tbl[6] = '{4'd15, 2, 2, 0};
        for (int i = 0; i < 4; i++) begin
            exp_edit_x[i] = i + 1;
            exp_edit_y[i] = i + 1;
        end

        // Reset state.
        repeat (2) @(negedge clk_in);
        check("rst_seed_load", int'(seed_load_out), 1);
        check("rst_seed_idx", int'(seed_idx_out), 0);
        check("rst_edit_valid", int'(edit_valid_out), 0);
        check("rst_edit_xy", int'({edit_y_out, edit_x_out}), 0);
        check("rst_step_valid", int'(step_valid_out), 0);
        check("rst_paused", int'(paused_out), 1);

        // Load held until seed_done, drops the cycle after.
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("load_hold", int'(seed_load_out), 1);
        end
        seed_done_in = 1'b1;
        check("load_at_done", int'(seed_load_out), 1);
        @(negedge clk_in);
        seed_done_in = 1'b0;
        check("load_after_done", int'(seed_load_out), 0);
        check("load_idx", int'(seed_idx_out), 0);

        // Step cadence table.
        for (int i = 0; i < 7; i++) begin
            speed_in = cad_tbl[i].speed;
            repeat (2) @(negedge clk_in);
            base = step_hs;
            step_seen = 1'b0;
            for (int f = 0; f < cad_tbl[i].frames; f++) frame();
            repeat (10) @(negedge clk_in);
            check($sformatf("cad_steps[%0d]", i), step_hs - base, cad_tbl[i].exp_steps);
            check($sformatf("cad_seen[%0d]", i), int'(step_seen), int'(cad_tbl[i].exp_steps > 0));
            check($sformatf("cad_paused[%0d]", i), int'(paused_out), cad_tbl[i].exp_paused);
        end

        // Five clicks while busy: four queued, fifth dropped, edits back-to-back.
        park_in_step_wait("park1_hs");
        base = ex_q.size();
        for (int i = 1; i <= 5; i++) click(i, i);
        pulse_step_done();
        repeat (20) @(negedge clk_in);
        nedits = ex_q.size() - base;
        check("fifo_edit_count", nedits, 4);
        for (int i = 0; i < 4 && i < nedits; i++) begin
            check($sformatf("fifo_edit_x[%0d]", i), ex_q[base + i], exp_edit_x[i]);
            check($sformatf("fifo_edit_y[%0d]", i), ey_q[base + i], exp_edit_y[i]);
            if (i > 0) check($sformatf("edit_gap[%0d]", i), ec_q[base + i] - ec_q[base + i - 1], 2);
        end

        // Seed change while busy with clicks queued: reload, queue flushed.
        park_in_step_wait("park2_hs");
        base = ex_q.size();
        click(7, 7);
        click(8, 8);
        seed_idx_in = 2'd3;
        repeat (2) @(negedge clk_in);
        check("seed_wait_no_load", int'(seed_load_out), 0);
        pulse_step_done();
        repeat (4) @(negedge clk_in);
        check("seed_reload", int'(seed_load_out), 1);
        check("seed_reload_idx", int'(seed_idx_out), 3);
        check("seed_no_edit_valid", int'(edit_valid_out), 0);
        pulse_seed_done();
        repeat (10) @(negedge clk_in);
        check("seed_loaded", int'(seed_load_out), 0);
        check("seed_flushed", ex_q.size() - base, 0);
        check("seed_flushed_valid", int'(edit_valid_out), 0);

        // Asynchronous reset during an edit.
        edit_ready_in = 1'b0;
        click(9, 9);
        click(10, 10);
        seen_valid = 1'b0;
        for (int i = 0; i < 20 && !seen_valid; i++) begin
            if (edit_valid_out) seen_valid = 1'b1;
            else @(negedge clk_in);
        end
        check("rst_mid_valid_before", int'(seen_valid), 1);
        check("rst_mid_x_before", int'(edit_x_out), 9);
        base = ex_q.size();
        rst_in = 1'b1;
        seed_idx_in = 2'd0;
        #1;
        check("rst_mid_edit_valid", int'(edit_valid_out), 0);
        check("rst_mid_seed_load", int'(seed_load_out), 1);
        check("rst_mid_seed_idx", int'(seed_idx_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        pulse_seed_done();
        edit_ready_in = 1'b1;
        repeat (10) @(negedge clk_in);
        check("rst_mid_fifo_discard", ex_q.size() - base, 0);
        check("rst_mid_idle_load", int'(seed_load_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_controller.md
# sim_controller

Sequencing stage directly downstream of `user_interface`. It takes the registered `click`, `speed`, `cursor` and `seed_idx` signals and the pipelined `vsync`. From these it issues three kinds of request to the board/life-engine stage, all mutually exclusive: seed loads, single-cell toggle edits, and generation steps. Clicks are buffered in a small FIFO while the engine is busy. Step cadence is derived from frame count and the speed setting.

## Interface
Parameters:
- `LOG_CLICK_DEPTH`, default 2: log2 of the click FIFO depth (4 entries).
- `LOG_BOARD_SIZE`, `LOG_MAX_SPEED`, `LOG_NUM_SEED`: taken from `common.svh`, not overridden.

Ports:
- `clk_in`  in  1: system clock.
- `rst_in`  in  1: reset, asynchronous, active-high.
- `click_in`  in  1: single-cycle click pulse.
- `speed_in`  in  `LOG_MAX_SPEED`: 0 means paused.
- `cursor_x_in`, `cursor_y_in`  in  `LOG_BOARD_SIZE` each: cursor cell.
- `seed_idx_in`  in  `LOG_NUM_SEED`: selected seed.
- `vsync_in`  in  1: pipelined vsync; its rising edge is the frame tick.
- `seed_load_out`  out  1: seed load request.
- `seed_idx_out`  out  `LOG_NUM_SEED`: seed being loaded.
- `seed_done_in`  in  1: one-cycle load-complete pulse.
- `edit_valid_out`  out  1: toggle request.
- `edit_x_out`, `edit_y_out`  out  `LOG_BOARD_SIZE` each: cell to toggle.
- `edit_ready_in`  in  1: edit accepted when high together with valid.
- `step_valid_out`  out  1: step request.
- `step_ready_in`  in  1: step accepted.
- `step_done_in`  in  1: one-cycle generation-complete pulse.
- `paused_out`  out  1: high when `speed_in == 0`.

## Operation
- FSM states: `LOAD`, `IDLE`, `EDIT`, `STEP_REQ`, `STEP_WAIT`.
- Reset values:
  - state `LOAD`, `seed_load_out=1`, `seed_idx_out=0`.
  - `edit_valid_out=0`, `step_valid_out=0`, edit coordinates 0.
  - `paused_out=1`, frame counter 0, pending-step flag 0, FIFO empty.
- `LOAD`:
  - Holds `seed_load_out`.
  - On `seed_done_in`: go to `IDLE`, clear frame counter and pending flag.
- `IDLE` priority, highest first:
  1. `seed_idx_in != seed_idx_out`: latch the new index, flush the FIFO, go to `LOAD`.
  2. FIFO non-empty: pop, go to `EDIT`.
  3. Pending flag set: go to `STEP_REQ`.
- `EDIT`:
  - `edit_valid_out` high with the popped coordinates.
  - On `edit_valid_out && edit_ready_in`: go to `IDLE`.
- `STEP_REQ`:
  - `step_valid_out` high.
  - On handshake: clear pending flag, go to `STEP_WAIT`.
- `STEP_WAIT`: on `step_done_in`, go to `IDLE`.
- Click FIFO:
  - Each `click_in` pushes `{cursor_y_in, cursor_x_in}` in any state except `LOAD`.
  - A push when full is dropped.
  - A push and pop in the same cycle are both honoured.
- Step cadence:
  - Period `P = 2**LOG_MAX_SPEED - speed_in` frames.
  - On each frame tick with `speed_in != 0`: if counter + 1 ≥ P, set the pending flag and zero the counter; else increment the counter.
  - While paused, the counter holds and the pending flag is not set. An already-set flag is still serviced.
- The pending flag saturates at 1; extra due steps while busy are dropped.
- A seed change during `EDIT`/`STEP_*` is taken on the next return to `IDLE`. An in-flight handshake is never abandoned.

## Timing
- Outputs are registered.
- `paused_out` follows `speed_in` by 1 cycle.
- Frame tick is detected 1 cycle after the `vsync_in` rising edge.
- `IDLE` → request asserted: 1 cycle.
- `seed_load_out` falls the cycle after `seed_done_in`.
- Edits are back-to-back: 2 cycles per edit minimum with `edit_ready_in` tied high (EDIT → IDLE → EDIT).
- `rst_in` asserted mid-operation: all outputs take reset values immediately (asynchronous reset). The FIFO contents are discarded.

## Structure
- `ctrl_state_t` enum and the FIFO entry struct `{y, x}` are added to the shared package in `common.svh`.
- Sub-module `click_fifo#(WIDTH, LOG_DEPTH)`: synchronous FIFO with push/pop/flush, `full`/`empty`, same async reset.
- Frame-edge detection and the cadence counter stay inline.

## Test plan
- Release reset with `seed_done_in` at cycle 5 → `seed_load_out=1`, `seed_idx_out=0` through cycle 5, low at cycle 6, state `IDLE`.
- `LOG_MAX_SPEED=4`, `speed_in=14` (P=2), 6 vsync edges, ready and done immediate → exactly 3 step handshakes.
- `speed_in=0`, 20 frames → no `step_valid_out`, `paused_out=1`.
- 5 clicks at cursors (1,1)…(5,5) during `STEP_WAIT`, then `step_done_in` → edits for (1,1)…(4,4) in order; 5th dropped.
- `seed_idx_in` changes 0→3 during `STEP_WAIT` with 2 clicks queued → after done: `LOAD` with `seed_idx_out=3`, FIFO flushed, no edits issued.
- `rst_in` pulsed while `edit_valid_out=1` → `edit_valid_out=0` in the same cycle, `seed_load_out=1`.
